logic_unit_pipe: RTL and testbench
==================================

Name: logic_unit_pipe

Overview:
- Parametrised, registered successor to the combinational 64-bit AND block.
- Executes bitwise AND / OR / XOR / ANDN on two WIDTH-bit operands, with one pipeline register and a valid/ready handshake.
- Produces zero and sign condition flags for the execute stage of the pipelined sequential processor.
- Keeps a saturating count of completed operations.

Parameters:
- WIDTH, 64, operand/result width in bits (legal range 8..128).
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand/op presented this cycle.
- in_ready  output  1  unit accepts the input this cycle.
- op  input  2  operation: 00 AND, 01 OR, 10 XOR, 11 ANDN (a & ~b).
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- out_valid  output  1  result register holds a valid result.
- out_ready  input  1  consumer takes the result this cycle.
- result  output  WIDTH  registered result.
- zf  output  1  registered zero flag: result == 0.
- sf  output  1  registered sign flag: result[WIDTH-1].
- op_count  output  CNT_W  number of results consumed, saturating.

Behaviour:
- Reset (asynchronous, rst=1):
  - out_valid=0, result=0, zf=0, sf=0, op_count=0.
  - in_ready is combinational and therefore reads 1 while out_valid=0.
  - Reset mid-operation discards the held result; no partial state survives.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational, no dependence on in_valid).
  - Input transfer (accept) = in_valid && in_ready.
  - Output transfer (consume) = out_valid && out_ready.
- Latency:
  - An input accepted at edge N appears on result/zf/sf with out_valid=1 after edge N.
  - Latency is 1 cycle.
  - Throughput is 1 op/cycle when out_ready is held high.
- Register update at each rising edge:
  - accept: result/zf/sf loaded from the combinational op of a, b; out_valid=1.
  - consume without accept: out_valid=0; result/zf/sf hold their last values.
  - accept and consume together: new result is loaded and out_valid stays 1. No bubble, no loss.
  - neither: all registers hold.
- Stall: while out_valid=1 and out_ready=0, in_ready=0. result, zf and sf must remain stable, and a/b/op changes are ignored.
- Flags: zf and sf are computed from the full WIDTH-bit result. No carry or overflow flags, since logic ops never set them; the downstream CC register treats them as 0.
- op_count:
  - Increments by 1 on each consume.
  - Saturates at 2^CNT_W-1 and never wraps.
  - Consume while saturated leaves it unchanged.
- Width rules: all ops are bitwise over WIDTH with no sign extension. Operands are treated as unsigned bit vectors; sign is interpreted only through sf.
- X-safety: in_valid=0 with X on a/b/op must not disturb the registered state.

Optional Feature:
- Macro: LOGIC_PARITY_EN.
- Defined:
  - Extra output port pf (1 bit), registered alongside zf/sf.
  - pf = 1 when result has an even number of 1 bits (x86 convention).
  - pf resets to 0 and holds during stalls exactly like zf/sf.
- Not defined: port pf is absent; no parity logic is synthesised; all other behaviour is identical.

Test Plan:
- Reset check: assert rst asynchronously mid-cycle after a loaded result -> out_valid, result, zf, sf, op_count go to 0 immediately, before the next clk edge; in_ready=1.
- Op coverage, WIDTH=64, out_ready=1, a=64'h7FFF_FFFF_FFFF_FFFF, b=64'h2:
  - AND -> result=64'h2, zf=0, sf=0.
  - OR -> 64'h7FFF_FFFF_FFFF_FFFF.
  - XOR -> 64'h7FFF_FFFF_FFFF_FFFD.
  - ANDN -> 64'h7FFF_FFFF_FFFF_FFFD.
  - Each appears one cycle after accept.
- Flags:
  - AND a=1, b=2 -> result=0, zf=1, sf=0.
  - OR a=64'h8000_0000_0000_0000, b=0 -> zf=0, sf=1.
  - AND a=3, b=7 -> result=3.
- Backpressure:
  - Accept op, then hold out_ready=0 for 3 cycles while changing a/b -> in_ready=0; result and flags are frozen.
  - Raise out_ready -> the same result is consumed; op_count=1.
- Back-to-back streaming: 8 ops on consecutive cycles with out_ready=1 -> 8 results in order, no bubbles, in_ready constantly 1, op_count=8.
- Saturation and parity:
  - With CNT_W=2, consume 5 results -> op_count=3 after the third and stays 3.
  - With LOGIC_PARITY_EN, XOR a=8'h00.., b=64'h3 -> pf=1; b=64'h1 -> pf=0.

Source files
------------

// File: rtl/logic_unit_pipe.sv
`default_nettype none
// ============================================================================
// Module   : logic_unit_pipe
// Purpose  : Registered bitwise logic unit (AND / OR / XOR / ANDN) with a
//            one-deep output register, valid/ready handshake, zero/sign
//            condition flags and a saturating count of consumed results.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   WIDTH  - operand/result width in bits (8..128)
//   CNT_W  - width of the consumed-result counter
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   in_valid   in   operands/op presented
//   in_ready   out  unit accepts input this cycle (combinational)
//   op         in   00 AND, 01 OR, 10 XOR, 11 ANDN (a & ~b)
//   a, b       in   WIDTH-bit operands
//   out_valid  out  result register holds a valid result
//   out_ready  in   consumer takes the result this cycle
//   result     out  registered result
//   zf         out  registered zero flag (result == 0)
//   sf         out  registered sign flag (result MSB)
//   op_count   out  saturating count of consumed results
//   pf         out  registered parity flag, 1 = even number of ones
//                   (present only when LOGIC_PARITY_EN is defined)
// Build option:
//   LOGIC_PARITY_EN - adds the pf output and its parity logic
// ============================================================================
module logic_unit_pipe #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic               zf,
  output logic               sf,
  output logic [CNT_W-1:0]   op_count
`ifdef LOGIC_PARITY_EN
  ,
  output logic               pf
`endif
);

  localparam logic [1:0]       c_OP_AND  = 2'b00;
  localparam logic [1:0]       c_OP_OR   = 2'b01;
  localparam logic [1:0]       c_OP_XOR  = 2'b10;
  localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             r_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_zf;
  logic             r_sf;
  logic [CNT_W-1:0] r_cnt;

  logic             w_accept;
  logic             w_consume;
  logic [WIDTH-1:0] w_res;

  // The output register can take new data when it is empty or being drained
  // in the same cycle; this gives full throughput without a skid buffer.
  assign in_ready  = !r_valid || out_ready;
  assign w_accept  = in_valid && in_ready;
  assign w_consume = r_valid && out_ready;

  always_comb begin
    w_res = a & ~b;
    case (op)
      c_OP_AND: w_res = a & b;
      c_OP_OR:  w_res = a | b;
      c_OP_XOR: w_res = a ^ b;
      default:  w_res = a & ~b;
    endcase
  end

  // Result and flags only load on accept, so X on a/b/op while in_valid=0
  // never reaches the registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid  <= 1'b0;
      r_result <= '0;
      r_zf     <= 1'b0;
      r_sf     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_valid  <= 1'b1;
        r_result <= w_res;
        r_zf     <= (w_res == '0);
        r_sf     <= w_res[WIDTH-1];
      end else if (w_consume) begin
        r_valid  <= 1'b0;
      end
    end
  end

  // Counter stops at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_consume && (r_cnt != c_CNT_MAX)) begin
      r_cnt <= r_cnt + c_CNT_ONE;
    end
  end

`ifdef LOGIC_PARITY_EN
  logic r_pf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pf <= 1'b0;
    end else if (w_accept) begin
      r_pf <= ~(^w_res);
    end
  end

  assign pf = r_pf;
`endif

  assign out_valid = r_valid;
  assign result    = r_result;
  assign zf        = r_zf;
  assign sf        = r_sf;
  assign op_count  = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_logic_unit_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_logic_unit_pipe
// Purpose  : Self-checking bench for logic_unit_pipe. A second instance with
//            CNT_W=2 shares all inputs so counter saturation is observed in
//            the same run.
// Revision : 1.0 - initial release
// ============================================================================
module tb_logic_unit_pipe;

  localparam int W = 64;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          out_ready;
  logic [1:0]    op;
  logic [W-1:0]  a;
  logic [W-1:0]  b;

  logic          in_ready,  s_in_ready;
  logic          out_valid, s_out_valid;
  logic [W-1:0]  result,    s_result;
  logic          zf, sf,    s_zf, s_sf;
  logic [15:0]   op_count;
  logic [1:0]    s_op_count;
`ifdef LOGIC_PARITY_EN
  logic          pf, s_pf;
`endif

  logic_unit_pipe #(.WIDTH(W), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zf(zf), .sf(sf), .op_count(op_count)
`ifdef LOGIC_PARITY_EN
    , .pf(pf)
`endif
  );

  logic_unit_pipe #(.WIDTH(W), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .op(op), .a(a), .b(b), .out_valid(s_out_valid), .out_ready(out_ready),
    .result(s_result), .zf(s_zf), .sf(s_sf), .op_count(s_op_count)
`ifdef LOGIC_PARITY_EN
    , .pf(s_pf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Expected results waiting in the output register (holds 0 or 1 entries).
  logic [W-1:0] q[$];
  int unsigned  n_cons;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_res;
    logic         exp_zf;
    logic         exp_sf;
  } vec_t;

  vec_t vecs[9];

  function automatic logic [W-1:0] ref_op(input logic [1:0] o,
                                          input logic [W-1:0] x,
                                          input logic [W-1:0] y);
    case (o)
      2'd0:    return x & y;
      2'd1:    return x | y;
      2'd2:    return x ^ y;
      default: return x & ~y;
    endcase
  endfunction

  function automatic int unsigned sat(input int unsigned n, input int unsigned mx);
    return (n > mx) ? mx : n;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check handshake and consumed data before
  // the edge, update the model at the edge, check counters after it.
  task automatic cycle(input logic v, input logic [1:0] o, input logic [W-1:0] ia,
                       input logic [W-1:0] ib, input logic ordy);
    logic acc, con;
    logic [W-1:0] e;
    in_valid  = v;
    op        = v ? o  : 2'bxx;
    a         = v ? ia : 'x;
    b         = v ? ib : 'x;
    out_ready = ordy;
    #1;
    chk("out_valid", out_valid, W'(q.size() != 0));
    chk("in_ready", in_ready, W'((q.size() == 0) || ordy));
    con = (q.size() != 0) && ordy;
    acc = v && ((q.size() == 0) || ordy);
    if (con) begin
      e = q[0];
      chk("result", result, e);
      chk("zf", zf, W'(e == '0));
      chk("sf", sf, W'(e[W-1]));
`ifdef LOGIC_PARITY_EN
      chk("pf", pf, W'(~(^e)));
`endif
    end
    @(posedge clk);
    if (con) begin
      void'(q.pop_front());
      n_cons++;
    end
    if (acc) q.push_back(ref_op(o, ia, ib));
    #1;
    chk("op_count", op_count, W'(sat(n_cons, 65535)));
    chk("sat_op_count", s_op_count, W'(sat(n_cons, 3)));
    @(negedge clk);
  endtask

  initial begin
    logic [W-1:0] held;
    logic [15:0]  cnt0;

    vecs[0] = '{2'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h2, 64'h2,                  1'b0, 1'b0};
    vecs[1] = '{2'd1, 64'h7FFF_FFFF_FFFF_FFFF, 64'h2, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
    vecs[2] = '{2'd2, 64'h7FFF_FFFF_FFFF_FFFF, 64'h2, 64'h7FFF_FFFF_FFFF_FFFD, 1'b0, 1'b0};
    vecs[3] = '{2'd3, 64'h7FFF_FFFF_FFFF_FFFF, 64'h2, 64'h7FFF_FFFF_FFFF_FFFD, 1'b0, 1'b0};
    vecs[4] = '{2'd0, 64'h1, 64'h2, 64'h0,                                    1'b1, 1'b0};
    vecs[5] = '{2'd1, 64'h8000_0000_0000_0000, 64'h0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
    vecs[6] = '{2'd0, 64'h3, 64'h7, 64'h3,                                    1'b0, 1'b0};
    vecs[7] = '{2'd2, {W{1'b1}}, {W{1'b1}}, 64'h0,                            1'b1, 1'b0};
    vecs[8] = '{2'd3, {W{1'b1}}, 64'h0, {W{1'b1}},                            1'b0, 1'b1};

    n_cons    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op        = 2'd0;
    a         = '0;
    b         = '0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, '0);
    chk("rst_result", result, '0);
    chk("rst_zf", zf, '0);
    chk("rst_sf", sf, '0);
    chk("rst_op_count", op_count, '0);
    chk("rst_in_ready", in_ready, 64'd1);
    rst = 1'b0;
    @(negedge clk);

    // Backpressure: one result held for 3 cycles while inputs keep changing.
    cycle(1'b1, 2'd2, 64'hDEAD_BEEF_0000_1111, 64'h0F0F_0F0F_0F0F_0F0F, 1'b0);
    held = q[0];
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 2'(i), {$urandom(), $urandom()}, {$urandom(), $urandom()}, 1'b0);
      chk("stall_result", result, held);
      chk("stall_zf", zf, W'(held == '0));
      chk("stall_sf", sf, W'(held[W-1]));
    end
    cycle(1'b0, 2'd0, '0, '0, 1'b1);
    chk("bp_op_count", op_count, 64'd1);

    // Directed vectors, one accept per cycle, each checked the cycle after.
    for (int i = 0; i < 9; i++) begin
      cycle(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, 1'b1);
      chk("vec_valid", out_valid, 64'd1);
      chk("vec_result", result, vecs[i].exp_res);
      chk("vec_zf", zf, W'(vecs[i].exp_zf));
      chk("vec_sf", sf, W'(vecs[i].exp_sf));
    end
    cycle(1'b0, 2'd0, '0, '0, 1'b1);

`ifdef LOGIC_PARITY_EN
    cycle(1'b1, 2'd2, 64'h0, 64'h3, 1'b1);
    chk("parity_even", pf, 64'd1);
    cycle(1'b1, 2'd2, 64'h0, 64'h1, 1'b1);
    chk("parity_odd", pf, 64'd0);
    cycle(1'b0, 2'd0, '0, '0, 1'b1);
`endif

    // Back-to-back streaming of 8 ops.
    cnt0 = op_count;
    for (int i = 0; i < 8; i++)
      cycle(1'b1, 2'(i % 4), {$urandom(), $urandom()}, {$urandom(), $urandom()}, 1'b1);
    cycle(1'b0, 2'd0, '0, '0, 1'b1);
    chk("stream_count", op_count, W'(cnt0 + 16'd8));
    chk("sat_hold", s_op_count, 64'd3);

    // Random traffic with random backpressure.
    for (int i = 0; i < 300; i++)
      cycle(($urandom_range(3) != 0), 2'($urandom_range(3)),
            {$urandom(), $urandom()}, {$urandom(), $urandom()},
            ($urandom_range(2) != 0));

    // Asynchronous reset mid-cycle with a result held.
    cycle(1'b1, 2'd1, 64'h8000_0000_0000_0001, 64'h10, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, '0);
    chk("arst_result", result, '0);
    chk("arst_zf", zf, '0);
    chk("arst_sf", sf, '0);
    chk("arst_op_count", op_count, '0);
    chk("arst_sat_count", s_op_count, '0);
    chk("arst_in_ready", in_ready, 64'd1);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    n_cons = 0;
    cycle(1'b1, 2'd0, 64'h3, 64'h7, 1'b1);
    cycle(1'b0, 2'd0, '0, '0, 1'b1);
    chk("post_rst_count", op_count, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
